// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// ALU opcodes, instruction opcodes/funct3 values and datapath mux selects.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // Which decode table the ALU decoder applies.
    typedef enum logic {
        CLS_ALU    = 1'b0,
        CLS_BRANCH = 1'b1
    } alu_class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format for the extender; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] sel;
        sel = IMM_I;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
// Handshake: MemReady high in a cycle means the memory finishes the access
// presented in that same cycle; the FSM holds every output stable until then.
// The FSM state is carried alongside for observation.
interface multicycle_control_if;
    import control_pkg::*;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       EQ;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUctrl;
    logic       Illegal;
    state_t     state;

    modport master (
        input  op, funct3, funct7b5, EQ, MemReady,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, Illegal, state
    );

    modport slave (
        output op, funct3, funct7b5, EQ, MemReady,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, Illegal, state
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the instruction class and function fields to an ALU
// opcode plus a valid bit. Build macro MULTICYCLE_BNE_EN makes bne legal;
// without it only beq is a recognised branch.
module alu_decoder
    import control_pkg::*;
(
    input  alu_class_t cls,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    // Decode table: R/I arithmetic or branch compare.
    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b0;
        if (cls == CLS_BRANCH) begin
            alu_ctrl = ALU_SUB;
`ifdef MULTICYCLE_BNE_EN
            valid = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
`else
            valid = (funct3 == F3_BEQ);
`endif
        end else begin
            case (funct3)
                F3_ADD: begin
                    // op5 separates R-type from I-type; addi has no sub form.
                    alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    valid    = 1'b1;
                end
                F3_XOR: begin
                    alu_ctrl = ALU_XOR;
                    valid    = 1'b1;
                end
                F3_AND: begin
                    alu_ctrl = ALU_AND;
                    valid    = 1'b1;
                end
                default: begin
                    alu_ctrl = ALU_ADD;
                    valid    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I datapath. Sequences fetch,
// decode and execute, driving mux selects and enables from the latched
// instruction fields. Whether bne is supported depends on MULTICYCLE_BNE_EN
// (resolved inside alu_decoder).
module multicycle_control
    import control_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);

    state_t     state;
    logic       is_alu_op;
    logic       is_branch;
    logic       is_known;
    alu_class_t dec_cls;
    logic [2:0] dec_alu;
    logic       dec_valid;
    logic       illegal_decode;

    assign is_alu_op = (bus.op == OP_R) || (bus.op == OP_I);
    assign is_branch = (bus.op == OP_BRANCH);
    assign is_known  = (bus.op == OP_LOAD) || (bus.op == OP_STORE) || (bus.op == OP_JAL);
    assign dec_cls   = is_branch ? CLS_BRANCH : CLS_ALU;

    alu_decoder u_alu_decoder (
        .cls      (dec_cls),
        .op5      (bus.op[5]),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .alu_ctrl (dec_alu),
        .valid    (dec_valid)
    );

    // Unsupported opcode, or supported opcode with an unsupported funct3.
    assign illegal_decode = (is_alu_op || is_branch) ? !dec_valid : !is_known;

    assign bus.state  = state;
    assign bus.ImmSrc = imm_src(bus.op);

    // State register and transitions; waits on MemReady in memory states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (bus.MemReady) state <= S_DECODE;
                S_DECODE: begin
                    if (illegal_decode)               state <= S_FETCH;
                    else if (bus.op == OP_LOAD ||
                             bus.op == OP_STORE)      state <= S_MEMADR;
                    else if (bus.op == OP_R)          state <= S_EXECUTER;
                    else if (bus.op == OP_I)          state <= S_EXECUTEI;
                    else if (bus.op == OP_BRANCH)     state <= S_BRANCH;
                    else                              state <= S_JAL;
                end
                S_MEMADR:   state <= (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (bus.MemReady) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (bus.MemReady) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Output decode from state; everything held at 0 while rst is high.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ALUctrl   = ALU_ADD;
        bus.Illegal   = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    bus.ALUSrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALURESULT;
                    bus.IRWrite   = bus.MemReady;
                    bus.PCWrite   = bus.MemReady;
                end
                S_DECODE: begin
                    bus.ALUSrcA = SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.Illegal = illegal_decode;
                end
                S_MEMADR: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    bus.AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    bus.ResultSrc = RES_DATA;
                    bus.RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                S_EXECUTER: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_RS2;
                    bus.ALUctrl = dec_alu;
                end
                S_EXECUTEI: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ALUctrl = dec_alu;
                end
                S_ALUWB: begin
                    bus.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_RS2;
                    bus.ALUctrl = ALU_SUB;
                    // Only beq/bne reach here; funct3[0] selects bne.
                    bus.PCWrite = bus.funct3[0] ? !bus.EQ : bus.EQ;
                end
                S_JAL: begin
                    bus.ALUSrcA = SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_FOUR;
                    bus.PCWrite = 1'b1;
                end
                default: begin
                    bus.PCWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each driven cycle pushes its
// hand-written expected control vector; a negedge monitor pops and compares.
module tb_multicycle_control;
    import control_pkg::*;

    localparam int W = 21;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    // Drive one cycle of inputs and queue the expected outputs for it.
    task automatic cyc(input string nm, input logic r, input logic mr, input logic eq,
                       input state_t st, input logic pcw, input logic adr, input logic irw,
                       input logic mw, input logic rw, input logic [1:0] rs,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
                       input logic [2:0] alu, input logic ill);
        rst          = r;
        bus.MemReady = mr;
        bus.EQ       = eq;
        exp_q.push_back({st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, ill});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic t_fetch(input string nm, input logic mr, input logic [1:0] imm);
        cyc(nm, 1'b0, mr, 1'b0, S_FETCH, mr, 1'b0, mr, 1'b0, 1'b0,
            2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endtask

    task automatic t_decode(input string nm, input logic [1:0] imm, input logic ill);
        cyc(nm, 1'b0, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
    endtask

    task automatic t_aluwb(input string nm, input logic [1:0] imm);
        cyc(nm, 1'b0, 1'b1, 1'b1, S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
    endtask

    // Scoreboard monitor: compare the full control vector every queued cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus.state, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
                  bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.ALUctrl, bus.Illegal};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: act=%h req=%h (t=%0t)", nm, a, e, $time);
            end
        end
    end

    // Directed stimulus
    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        bus.MemReady = 1'b1;
        bus.EQ       = 1'b0;
        set_instr(OP_LOAD, 3'b010, 1'b0);
        @(posedge clk);
        #1;

        // Reset: state FETCH, everything zero.
        cyc("reset0", 1'b1, 1'b1, 1'b0, S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        cyc("reset1", 1'b1, 1'b1, 1'b0, S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);

        // lw, MemReady high: 5 cycles.
        t_fetch("lw_fetch", 1'b1, 2'b00);
        t_decode("lw_decode", 2'b00, 1'b0);
        cyc("lw_memadr", 0, 1, 0, S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        cyc("lw_memread", 0, 1, 0, S_MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        cyc("lw_memwb", 0, 1, 0, S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);

        // lw with one wait cycle in MEMREAD.
        t_fetch("lw2_fetch", 1'b1, 2'b00);
        t_decode("lw2_decode", 2'b00, 1'b0);
        cyc("lw2_memadr", 0, 1, 0, S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        cyc("lw2_memread_wait", 0, 0, 0, S_MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        cyc("lw2_memread", 0, 1, 0, S_MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        cyc("lw2_memwb", 0, 1, 0, S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);

        // Reset asserted in MEMREAD aborts the load.
        t_fetch("rlw_fetch", 1'b1, 2'b00);
        t_decode("rlw_decode", 2'b00, 1'b0);
        cyc("rlw_memadr", 0, 1, 0, S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        cyc("rlw_rst_in_memread", 1, 1, 0, S_MEMREAD, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        cyc("rlw_rst_fetch", 1, 1, 0, S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);

        // sw with one MemReady-low cycle in MEMWRITE.
        set_instr(OP_STORE, 3'b010, 1'b0);
        t_fetch("sw_fetch_after_rst", 1'b1, 2'b01);
        t_decode("sw_decode", 2'b01, 1'b0);
        cyc("sw_memadr", 0, 1, 0, S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
        cyc("sw_memwrite_wait", 0, 0, 0, S_MEMWRITE, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        cyc("sw_memwrite", 0, 1, 0, S_MEMWRITE, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);

        // R-type sub with MemReady low for 3 cycles in FETCH.
        set_instr(OP_R, 3'b000, 1'b1);
        t_fetch("sub_fetch_wait0", 1'b0, 2'b00);
        t_fetch("sub_fetch_wait1", 1'b0, 2'b00);
        t_fetch("sub_fetch_wait2", 1'b0, 2'b00);
        t_fetch("sub_fetch", 1'b1, 2'b00);
        t_decode("sub_decode", 2'b00, 1'b0);
        cyc("sub_exec", 0, 1, 0, S_EXECUTER, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
        t_aluwb("sub_aluwb", 2'b00);

        // Same fields as I-type: add, not sub.
        set_instr(OP_I, 3'b000, 1'b1);
        t_fetch("addi_fetch", 1'b1, 2'b00);
        t_decode("addi_decode", 2'b00, 1'b0);
        cyc("addi_exec", 0, 1, 0, S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        t_aluwb("addi_aluwb", 2'b00);

        // R-type xor.
        set_instr(OP_R, 3'b100, 1'b0);
        t_fetch("xor_fetch", 1'b1, 2'b00);
        t_decode("xor_decode", 2'b00, 1'b0);
        cyc("xor_exec", 0, 1, 0, S_EXECUTER, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b100, 0);
        t_aluwb("xor_aluwb", 2'b00);

        // I-type and.
        set_instr(OP_I, 3'b111, 1'b0);
        t_fetch("andi_fetch", 1'b1, 2'b00);
        t_decode("andi_decode", 2'b00, 1'b0);
        cyc("andi_exec", 0, 1, 0, S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010, 0);
        t_aluwb("andi_aluwb", 2'b00);

        // beq taken and not taken.
        set_instr(OP_BRANCH, 3'b000, 1'b0);
        t_fetch("beq1_fetch", 1'b1, 2'b10);
        t_decode("beq1_decode", 2'b10, 1'b0);
        cyc("beq_eq1", 0, 1, 1, S_BRANCH, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
        t_fetch("beq0_fetch", 1'b1, 2'b10);
        t_decode("beq0_decode", 2'b10, 1'b0);
        cyc("beq_eq0", 0, 1, 0, S_BRANCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);

        // bne.
        set_instr(OP_BRANCH, 3'b001, 1'b0);
`ifdef MULTICYCLE_BNE_EN
        t_fetch("bne1_fetch", 1'b1, 2'b10);
        t_decode("bne1_decode", 2'b10, 1'b0);
        cyc("bne_eq1", 0, 1, 1, S_BRANCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
        t_fetch("bne0_fetch", 1'b1, 2'b10);
        t_decode("bne0_decode", 2'b10, 1'b0);
        cyc("bne_eq0", 0, 1, 0, S_BRANCH, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
`else
        t_fetch("bne_fetch", 1'b1, 2'b10);
        t_decode("bne_illegal", 2'b10, 1'b1);
`endif

        // jal: PCWrite in JAL, then PC+4 written in ALUWB.
        set_instr(OP_JAL, 3'b000, 1'b0);
        t_fetch("jal_fetch", 1'b1, 2'b11);
        t_decode("jal_decode", 2'b11, 1'b0);
        cyc("jal_jal", 0, 1, 0, S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
        t_aluwb("jal_aluwb", 2'b11);

        // Unsupported opcode (system).
        set_instr(7'b1110011, 3'b000, 1'b0);
        t_fetch("sys_fetch", 1'b1, 2'b00);
        t_decode("sys_illegal", 2'b00, 1'b1);

        // Supported opcode, unsupported funct3.
        set_instr(OP_R, 3'b001, 1'b0);
        t_fetch("sll_fetch", 1'b1, 2'b00);
        t_decode("sll_illegal", 2'b00, 1'b1);

        // Back in FETCH after the illegal decode, waiting on memory.
        set_instr(OP_LOAD, 3'b010, 1'b0);
        t_fetch("post_illegal_fetch", 1'b0, 2'b00);

        // Let the monitor drain the last queued cycle.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: act=%0d left req=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV32I datapath; the sequencing end of the ALU interface. Drives the ALU opcode (`ALUctrl`) plus every datapath mux select and write enable from the latched instruction fields. Consumes the ALU's `EQ` flag to resolve branches. Supports the subset the ALU implements: lw, sw, R/I-type add/sub/and/xor, beq, bne, jal.

## Interface

Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: opcode bits [6:0] of the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `EQ` in 1: ALU equality flag, valid in the cycle the ALU is driven.
- `MemReady` in 1: unified memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction/OldPC register enable.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register-file write enable.
- `ResultSrc` out 2: result mux select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: SrcA select; 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: SrcB select; 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format, combinational from `op`; I = 00, S = 01, B = 10, J = 11.
- `ALUctrl` out 3: 000 add, 001 sub, 010 and, 100 xor.
- `Illegal` out 1: one-cycle pulse when an unsupported instruction is decoded.

## Operation

- States:
  - FETCH, DECODE: common to every instruction.
  - MEMADR, MEMREAD, MEMWB, MEMWRITE: loads and stores.
  - EXECUTER, EXECUTEI, ALUWB: register and immediate ALU ops.
  - BRANCH, JAL: control transfer.
- Outputs are a pure function of state, plus `MemReady`/`EQ` where noted. Every signal not listed for a state is 0.
- FETCH:
  - Fixed controls: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10.
  - Waits until `MemReady`; IRWrite and PCWrite are asserted only in the `MemReady` cycle, then the FSM moves to DECODE.
- DECODE:
  - Precomputes the branch target: ALUSrcA=01, ALUSrcB=01, add.
  - Next state by `op`:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - anything else -> FETCH with `Illegal`=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until `MemReady`, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite is held high until the `MemReady` cycle inclusive, then FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=10, ALUSrcB=00 or 01 respectively, ALUctrl decoded. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=sub, ResultSrc=00.
  - PCWrite = EQ for funct3=000 (beq).
  - PCWrite = !EQ for funct3=001 (bne; see Configuration).
  - Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (writes PC+4 to rd).
- ALU decode, shared by EXECUTER and EXECUTEI:
  - funct3 000 -> add; sub only for R-type with funct7b5=1.
  - funct3 100 -> xor.
  - funct3 111 -> and.
  - Other funct3, or unsupported branch funct3: `Illegal` pulses in DECODE and the FSM returns to FETCH; no register or memory write occurs.

## Timing

- Reset:
  - While `rst` is high: state <= FETCH, and all outputs except ImmSrc are forced to 0 (including ALUctrl=000, Illegal=0).
  - First fetch begins in the cycle after `rst` deasserts.
  - Reset in any state aborts the instruction; no enable is asserted during the reset cycle.
- Latency with `MemReady` tied high:
  - lw 5 cycles.
  - sw, R-type, I-type, jal 4 cycles.
  - beq/bne 3 cycles.
  - Illegal 2 cycles.
- Each cycle `MemReady` is low in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while waiting.
- `EQ` is sampled combinationally in BRANCH only; `EQ` in any other state is ignored.

## Configuration

- Macro: `MULTICYCLE_BNE_EN`.
- Defined: bne is decoded as above.
- Undefined: branch funct3=001 is illegal, meaning an `Illegal` pulse in DECODE and a return to FETCH; beq is unaffected.

## Structure

- Package `control_pkg` holds:
  - the state enum;
  - ALUctrl constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR);
  - opcode constants;
  - ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module `alu_decoder`: combinational; maps (state class, op5, funct3, funct7b5) to ALUctrl and a decode-valid bit.

## Test plan

- Reset mid-instruction: assert `rst` in MEMREAD -> next cycle state is FETCH and all enables are 0; a fetch completes 1 cycle after release.
- lw (op=0000011) with `MemReady`=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite high only in cycle 5 with ResultSrc=01.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUctrl=001 in EXECUTER, then RegWrite in ALUWB. The same fields with op=0010011 give ALUctrl=000.
- beq with EQ=1 -> PCWrite=1 in BRANCH. bne with EQ=1 -> PCWrite=0, and with the macro undefined -> `Illegal`=1 in DECODE.
- `MemReady` low for 3 cycles in FETCH -> IRWrite/PCWrite stay 0 for 3 cycles, then a single-cycle pulse.
- op=1110011 -> `Illegal` pulse in DECODE, no RegWrite/MemWrite, FETCH on the next cycle.
